// File: rtl/adder_pkg.sv
// Shared types and constants for the arbitrated sign-magnitude/unsigned adder.
package adder_pkg;

  localparam int DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/sm_adder8.sv
// Combinational 8-bit adder: unsigned (9-bit sum) or sign-magnitude with
// magnitude-overflow flag and sign taken from the larger magnitude.
module sm_adder8
  import adder_pkg::*;
(
  input  logic          iSA,
  input  logic [DW-1:0] iData_a,
  input  logic [DW-1:0] iData_b,
  output logic [DW:0]   oData,
  output logic          oData_C
);

  logic [DW-2:0] magA_s;
  logic [DW-2:0] magB_s;
  logic [DW-1:0] magSum_s;
  logic [DW:0]   uSum_s;

  assign magA_s   = iData_a[DW-2:0];
  assign magB_s   = iData_b[DW-2:0];
  assign uSum_s   = {1'b0, iData_a} + {1'b0, iData_b};
  assign magSum_s = {1'b0, magA_s} + {1'b0, magB_s};

  // Select result by mode and sign relationship; equal magnitudes of opposite sign give +0
  always_comb begin
    oData   = '0;
    oData_C = 1'b0;
    if (!iSA) begin
      oData   = uSum_s;
      oData_C = uSum_s[DW];
    end else if (iData_a[DW-1] == iData_b[DW-1]) begin
      oData   = {iData_a[DW-1], magSum_s};
      oData_C = magSum_s[DW-1];
    end else if (magA_s > magB_s) begin
      oData   = {iData_a[DW-1], 1'b0, magA_s - magB_s};
      oData_C = 1'b0;
    end else if (magB_s > magA_s) begin
      oData   = {iData_b[DW-1], 1'b0, magB_s - magA_s};
      oData_C = 1'b0;
    end else begin
      oData   = '0;
      oData_C = 1'b0;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one sm_adder8 among NREQ requesters with
// valid/ready on both sides; responses are tagged with the requester ID.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [NREQ-1:0]  iReq_valid,
  output logic [NREQ-1:0]  oReq_ready,
  input  logic [NREQ-1:0]  iReq_sa,
  input  logic [DW*NREQ-1:0] iReq_a,
  input  logic [DW*NREQ-1:0] iReq_b,
  output logic             oRsp_valid,
  input  logic             iRsp_ready,
  output logic [IDW-1:0]   oRsp_id,
  output logic [DW:0]      oRsp_data,
  output logic             oRsp_c
);

  state_t          state_r;
  logic [IDW-1:0]  ptr_r;
  logic [IDW-1:0]  id_r;
  logic            sa_r;
  logic [DW-1:0]   a_r;
  logic [DW-1:0]   b_r;
  logic            rspValid_r;
  logic [DW:0]     rspData_r;
  logic            rspC_r;

  logic [IDW-1:0]  winner_s;
  logic            anyValid_s;
  logic [IDW-1:0]  nextPtr_s;
  logic [NREQ-1:0] ready_s;
  logic [DW:0]     sum_s;
  logic            sumC_s;

  sm_adder8 uAdder (
    .iSA     (sa_r),
    .iData_a (a_r),
    .iData_b (b_r),
    .oData   (sum_s),
    .oData_C (sumC_s)
  );

  // Scan from the farthest offset down so the request closest to ptr wins
  always_comb begin
    logic [IDW:0]   raw;
    logic [IDW-1:0] idx;
    winner_s   = '0;
    anyValid_s = 1'b0;
    raw        = '0;
    idx        = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      raw        = {1'b0, ptr_r} + (IDW+1)'(i);
      idx        = (raw >= (IDW+1)'(NREQ)) ? IDW'(raw - (IDW+1)'(NREQ)) : raw[IDW-1:0];
      winner_s   = iReq_valid[idx] ? idx : winner_s;
      anyValid_s = anyValid_s | iReq_valid[idx];
    end
  end

  // Grant is offered only while idle
  always_comb begin
    ready_s = '0;
    if ((state_r == ST_IDLE) && anyValid_s) begin
      ready_s[winner_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign nextPtr_s  = (id_r == IDW'(NREQ - 1)) ? '0 : id_r + IDW'(1);
  assign oReq_ready = ready_s;
  assign oRsp_valid = rspValid_r;
  assign oRsp_id    = id_r;
  assign oRsp_data  = rspData_r;
  assign oRsp_c     = rspC_r;

  // Control FSM: capture operands, register the sum, hold the response until taken
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      id_r       <= '0;
      sa_r       <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      rspValid_r <= 1'b0;
      rspData_r  <= '0;
      rspC_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (anyValid_s) begin
            sa_r    <= iReq_sa[winner_s];
            a_r     <= iReq_a[int'(winner_s)*DW +: DW];
            b_r     <= iReq_b[int'(winner_s)*DW +: DW];
            id_r    <= winner_s;
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rspData_r  <= sum_s;
          rspC_r     <= sumC_s;
          rspValid_r <= 1'b1;
          state_r    <= ST_RESP;
        end
        ST_RESP: begin
          if (iRsp_ready) begin
            rspValid_r <= 1'b0;
            ptr_r      <= nextPtr_s;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          rspValid_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomised and directed bench for adder_arbiter against a transaction-level
// reference model (integer arithmetic, round-robin search over a pointer).
module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic [3:0]  iReq_valid;
  logic [3:0]  oReq_ready;
  logic [3:0]  iReq_sa;
  logic [31:0] iReq_a;
  logic [31:0] iReq_b;
  logic        oRsp_valid;
  logic        iRsp_ready;
  logic [1:0]  oRsp_id;
  logic [8:0]  oRsp_data;
  logic        oRsp_c;

  logic [7:0]  opA [NREQ];
  logic [7:0]  opB [NREQ];
  logic        opSa[NREQ];
  int          modelPtr;
  int          errors;
  int          checks;
  int          lastId;
  logic [8:0]  lastData;
  logic        lastC;

  adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iReq_valid (iReq_valid),
    .oReq_ready (oReq_ready),
    .iReq_sa    (iReq_sa),
    .iReq_a     (iReq_a),
    .iReq_b     (iReq_b),
    .oRsp_valid (oRsp_valid),
    .iRsp_ready (iRsp_ready),
    .oRsp_id    (oRsp_id),
    .oRsp_data  (oRsp_data),
    .oRsp_c     (oRsp_c)
  );

  always #5 iClk = ~iClk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int refWinner(input logic [3:0] mask, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (mask[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // Returns {carry, data[8:0]} computed from signed integer values
  function automatic logic [9:0] refAdd(input logic sa, input logic [7:0] a, input logic [7:0] b);
    int va, vb, s, mag;
    logic sign, c;
    if (!sa) begin
      s = int'(a) + int'(b);
      return {s[8], s[8:0]};
    end
    va   = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
    vb   = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
    s    = va + vb;
    mag  = (s < 0) ? -s : s;
    sign = (s < 0) || ((s == 0) && a[7] && b[7]);
    c    = (a[7] == b[7]) && (mag > 127);
    return {c, sign, mag[7:0]};
  endfunction

  task automatic drivePack();
    for (int k = 0; k < NREQ; k++) begin
      iReq_a[8*k +: 8] = opA[k];
      iReq_b[8*k +: 8] = opB[k];
      iReq_sa[k]       = opSa[k];
    end
  endtask

  function automatic logic [7:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Starts and ends on a falling edge with the DUT idle
  task automatic doOp(input logic [3:0] mask, input int hold);
    int w;
    logic [9:0] exp;
    iReq_valid = mask;
    iRsp_ready = 1'b0;
    drivePack();
    #1;
    w = refWinner(mask, modelPtr);
    if (w < 0) begin
      checkEq("idle_ready", 32'(oReq_ready), 32'd0);
      @(negedge iClk);
      checkEq("idle_valid", 32'(oRsp_valid), 32'd0);
    end else begin
      checkEq("grant", 32'(oReq_ready), 32'd1 << w);
      exp = refAdd(opSa[w], opA[w], opB[w]);
      @(posedge iClk);
      #1;
      opA[w]  = pickOperand();
      opB[w]  = pickOperand();
      opSa[w] = 1'($urandom_range(0, 1));
      drivePack();
      @(negedge iClk);
      checkEq("exec_ready", 32'(oReq_ready), 32'd0);
      checkEq("exec_valid", 32'(oRsp_valid), 32'd0);
      @(negedge iClk);
      for (int h = 0; h <= hold; h++) begin
        iRsp_ready = (h == hold);
        #1;
        checkEq("rsp_valid", 32'(oRsp_valid), 32'd1);
        checkEq("rsp_id", 32'(oRsp_id), 32'(w));
        checkEq("rsp_data", 32'(oRsp_data), 32'(exp[8:0]));
        checkEq("rsp_c", 32'(oRsp_c), 32'(exp[9]));
        checkEq("rsp_ready", 32'(oReq_ready), 32'd0);
        if (h < hold) @(negedge iClk);
      end
      lastId   = int'(oRsp_id);
      lastData = oRsp_data;
      lastC    = oRsp_c;
      @(negedge iClk);
      iRsp_ready = 1'b0;
      modelPtr   = (w + 1) % NREQ;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int expOrder[5];
    errors = 0;
    checks = 0;
    modelPtr = 0;
    iRst_n = 1'b0;
    iReq_valid = 4'd0;
    iRsp_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      opA[k] = 8'd0;
      opB[k] = 8'd0;
      opSa[k] = 1'b0;
    end
    drivePack();
    repeat (3) @(negedge iClk);
    checkEq("rst_ready", 32'(oReq_ready), 32'd0);
    checkEq("rst_valid", 32'(oRsp_valid), 32'd0);
    checkEq("rst_id", 32'(oRsp_id), 32'd0);
    checkEq("rst_data", 32'(oRsp_data), 32'd0);
    checkEq("rst_c", 32'(oRsp_c), 32'd0);
    iRst_n = 1'b1;
    @(negedge iClk);

    // Unsigned carry out
    opSa[0] = 1'b0; opA[0] = 8'hFF; opB[0] = 8'h01;
    doOp(4'b0001, 0);
    checkEq("t_uns_data", 32'(lastData), 32'h100);
    checkEq("t_uns_c", 32'(lastC), 32'd1);

    // Signed same sign, overflow then small
    opSa[2] = 1'b1; opA[2] = 8'h85; opB[2] = 8'hFE;
    doOp(4'b0100, 0);
    checkEq("t_ss_data", 32'(lastData), 32'h183);
    checkEq("t_ss_c", 32'(lastC), 32'd1);
    opSa[2] = 1'b1; opA[2] = 8'h03; opB[2] = 8'h04;
    doOp(4'b0100, 1);
    checkEq("t_ss2_data", 32'(lastData), 32'h007);
    checkEq("t_ss2_c", 32'(lastC), 32'd0);

    // Signed mixed sign, then equal magnitudes giving +0
    opSa[3] = 1'b1; opA[3] = 8'h05; opB[3] = 8'h8A;
    doOp(4'b1000, 0);
    checkEq("t_mx_data", 32'(lastData), 32'h105);
    checkEq("t_mx_c", 32'(lastC), 32'd0);
    opSa[3] = 1'b1; opA[3] = 8'h8A; opB[3] = 8'h0A;
    doOp(4'b1000, 0);
    checkEq("t_zero_data", 32'(lastData), 32'h000);

    // Round robin with everyone valid
    expOrder = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      doOp(4'b1111, 0);
      checkEq("rr_order", 32'(lastId), 32'(expOrder[i]));
    end

    // Backpressure
    doOp(4'b1111, 5);
    doOp(4'b1111, 0);

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          opA[k]  = pickOperand();
          opB[k]  = pickOperand();
          opSa[k] = 1'($urandom_range(0, 1));
        end
      end
      doOp(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in EXEC, off the clock edge
    opSa[1] = 1'b0; opA[1] = 8'hC3; opB[1] = 8'h5A;
    iReq_valid = 4'b0010;
    drivePack();
    #1;
    checkEq("pre_rst_grant", 32'(oReq_ready), 32'd1 << refWinner(4'b0010, modelPtr));
    @(posedge iClk);
    #2;
    iReq_valid = 4'd0;
    iRst_n = 1'b0;
    #1;
    checkEq("arst_ready", 32'(oReq_ready), 32'd0);
    checkEq("arst_valid", 32'(oRsp_valid), 32'd0);
    checkEq("arst_id", 32'(oRsp_id), 32'd0);
    checkEq("arst_data", 32'(oRsp_data), 32'd0);
    checkEq("arst_c", 32'(oRsp_c), 32'd0);
    @(negedge iClk);
    iRst_n = 1'b1;
    modelPtr = 0;
    @(negedge iClk);
    checkEq("post_rst_valid", 32'(oRsp_valid), 32'd0);
    opSa[3] = 1'b1; opA[3] = 8'h80; opB[3] = 8'h80;
    doOp(4'b1000, 1);
    checkEq("post_rst_id", 32'(lastId), 32'd3);
    checkEq("negzero_data", 32'(lastData), 32'h100);
    checkEq("negzero_c", 32'(lastC), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 8-bit sign-magnitude/unsigned adder (sub-module sm_adder8) among NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Operands are captured into registers and the adder result is registered.
- Each response is returned tagged with the ID of the requester that issued it.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width = max(1, clog2(NREQ))

Ports:
iClk  input  1  clock, all state on rising edge
iRst_n  input  1  asynchronous active-low reset
iReq_valid  input  NREQ  per-requester request valid
oReq_ready  output  NREQ  per-requester accept (one-hot or zero)
iReq_sa  input  NREQ  per-requester mode: 1 = sign-magnitude, 0 = unsigned
iReq_a  input  8*NREQ  operand a, requester k at [8k+7:8k]
iReq_b  input  8*NREQ  operand b, same packing
oRsp_valid  output  1  result valid
iRsp_ready  input  1  consumer accepts result
oRsp_id  output  IDW  requester ID of the result
oRsp_data  output  9  sum; in signed mode bit8 = sign
oRsp_c  output  1  carry/overflow flag

Behaviour:
- Reset values (asynchronous, on iRst_n=0):
  - state=IDLE, priority pointer ptr=0.
  - oReq_ready=0, oRsp_valid=0, oRsp_id=0, oRsp_data=0, oRsp_c=0.
  - Any operation in flight is discarded with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner w = first k with iReq_valid[k]=1, searching ptr, ptr+1, ... modulo NREQ.
  - oReq_ready[w]=1 combinationally, only in IDLE; all other ready bits are 0.
  - On the handshake, capture sa/a/b of w and the id w, then go to EXEC.
  - No valid request: stay in IDLE.
- EXEC (1 cycle):
  - sm_adder8 evaluates the captured operands.
  - oRsp_data and oRsp_c are registered, then go to RESP.
- RESP:
  - oRsp_valid=1; id, data and c are held stable until iRsp_ready=1.
  - On handshake: ptr = (w+1) mod NREQ, go to IDLE.
  - If iRsp_ready is already 1 on the first RESP cycle, exit after that cycle.
- Latency and throughput:
  - Request handshake to oRsp_valid: 2 cycles.
  - Best-case throughput: one operation per 3 cycles.
- Fairness: a continuously valid requester is granted within NREQ operations; no starvation.
- Requesters must hold valid and operands stable until ready. Deasserting valid before grant is legal and simply drops the request from arbitration.
- Arithmetic, unsigned (sa=0):
  - oRsp_data = {0,a} + {0,b}, 9-bit result.
  - oRsp_c = oRsp_data[8].
- Arithmetic, sign-magnitude (sa=1): bit7 = sign, [6:0] = magnitude.
  - Same signs:
    - data[7:0] = a[6:0] + b[6:0], 8-bit magnitude.
    - data[8] = common sign.
    - c = data[7] (magnitude overflow).
  - Different signs:
    - data[6:0] = |mag_a − mag_b| and data[7] = 0.
    - data[8] = sign of the larger-magnitude operand.
    - c = 0.
  - Equal magnitudes with different signs give +0 (data=0).
  - −0 inputs are treated as magnitude 0 with their sign bit; −0 + −0 = 9'h100.
- Reset mid-operation (EXEC or RESP): returns to IDLE with ptr=0. The requester does not re-receive ready for the lost operation unless it requests again.

Decomposition:
- Shared package adder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2;
  - the operand width constant DW=8.
- Sub-module sm_adder8: purely combinational adder implementing the arithmetic rules above, exactly as specified.
  - Ports: iSA, iData_a[7:0], iData_b[7:0], oData[8:0], oData_C.
  - Instantiated once inside adder_arbiter.
- adder_arbiter contains only the FSM, round-robin logic and registers.

Test Plan:
- Unsigned (NREQ=4): req0 only, sa=0, a=8'hFF, b=8'h01 → ready[0] pulses 1 cycle; 2 cycles later oRsp_valid=1, id=0, data=9'h100, c=1.
- Signed, same sign: req2, a=8'h85 (−5), b=8'hFE (−126) → data=9'h183, c=1. Then req2, a=8'h03, b=8'h04 → data=9'h007, c=0.
- Signed, mixed sign: a=8'h05, b=8'h8A (−10) → data=9'h105, c=0. Then a=8'h8A, b=8'h0A → data=9'h000 (+0), c=0.
- Round-robin: all 4 valid continuously with iRsp_ready=1 → grant order 0,1,2,3,0; each response id matches its grant; next ready arrives ≥3 cycles after the previous one.
- Backpressure: iRsp_ready=0 for 5 cycles in RESP → oRsp_valid, id, data and c held stable; no oReq_ready asserted; on iRsp_ready=1, one cycle later the next grant appears.
- Async reset: assert iRst_n=0 mid-EXEC, off clock edge → all outputs 0 immediately. After release with req3 valid → grant goes to 3 (ptr=0 search), correct result returned.
